// File: rtl/hazard_scoreboard.sv
// Load-use / branch-operand hazard scoreboard for the 5-stage pipeline ID stage.
// Optional stall statistics are enabled with `define HAZARD_STALL_COUNT_EN.
module hazard_scoreboard #(
   parameter int LOAD_EX_WAIT = 1,
   parameter int LOAD_ID_WAIT = 2,
   parameter int ALU_ID_WAIT  = 1
) (
   input  logic        CLOCK,
   input  logic        RESET,
   input  logic [31:0] Instruction_IN,
   input  logic        ID_Valid,
   input  logic        ID_UsesRS,
   input  logic        ID_UsesRT,
   input  logic        ID_Branch,
   input  logic        ID_RegWrite,
   input  logic        ID_MemRead,
   input  logic [4:0]  ID_RegD,
   input  logic        FLUSH,
   output logic        STALL,
   output logic        PC_Write,
   output logic        IFID_Write,
   output logic        IDEX_Bubble,
   output logic [31:0] STALL_CYCLES
);

   localparam logic [1:0] LD_EX_W  = LOAD_EX_WAIT[1:0];
   localparam logic [1:0] LD_ID_W  = LOAD_ID_WAIT[1:0];
   localparam logic [1:0] ALU_ID_W = ALU_ID_WAIT[1:0];

   logic [4:0] rs;
   logic [4:0] rt;
   logic       unused_instr_bits;

   assign rs = Instruction_IN[25:21];
   assign rt = Instruction_IN[20:16];
   assign unused_instr_bits = ^{Instruction_IN[31:26], Instruction_IN[15:0]};

   logic [1:0] ex_wait [32];
   logic [1:0] id_wait [32];

   logic haz_ex;
   logic haz_id;
   logic issue;

   always_comb begin
      haz_ex = (ID_UsesRS && (ex_wait[rs] != 2'd0)) ||
               (ID_UsesRT && (ex_wait[rt] != 2'd0));
      haz_id = ID_Branch &&
               ((ID_UsesRS && (id_wait[rs] != 2'd0)) ||
                (ID_UsesRT && (id_wait[rt] != 2'd0)));
   end

   assign STALL       = ID_Valid && !FLUSH && (haz_ex || haz_id);
   assign PC_Write    = !STALL;
   assign IFID_Write  = !STALL;
   assign IDEX_Bubble = STALL;

   // Lookups above use pre-issue state, so a self-dependent instruction never sees its own entry.
   assign issue = ID_Valid && !STALL && !FLUSH && ID_RegWrite && (ID_RegD != 5'd0);

   genvar gi;
   generate
      for (gi = 0; gi < 32; gi++) begin : g_entry
         if (gi == 0) begin : g_zero
            assign ex_wait[gi] = 2'd0;
            assign id_wait[gi] = 2'd0;
         end else begin : g_track
            logic [1:0] ex_reg;
            logic [1:0] id_reg;
            logic [1:0] ex_next;
            logic [1:0] id_next;
            logic       hit;

            assign hit = issue && (ID_RegD == 5'(gi));

            // Youngest producer wins: an issue overwrites any older pending write.
            always_comb begin
               ex_next = (ex_reg != 2'd0) ? ex_reg - 2'd1 : 2'd0;
               id_next = (id_reg != 2'd0) ? id_reg - 2'd1 : 2'd0;
               if (hit) begin
                  ex_next = ID_MemRead ? LD_EX_W : 2'd0;
                  id_next = ID_MemRead ? LD_ID_W : ALU_ID_W;
               end
            end

            always_ff @(posedge CLOCK or negedge RESET) begin
               if (!RESET) begin
                  ex_reg <= 2'd0;
                  id_reg <= 2'd0;
               end else begin
                  ex_reg <= ex_next;
                  id_reg <= id_next;
               end
            end

            assign ex_wait[gi] = ex_reg;
            assign id_wait[gi] = id_reg;
         end
      end
   endgenerate

`ifdef HAZARD_STALL_COUNT_EN
   logic [31:0] stall_cycles_reg;
   logic [31:0] stall_cycles_next;

   always_comb begin
      stall_cycles_next = stall_cycles_reg;
      if (STALL && (stall_cycles_reg != 32'hFFFF_FFFF)) begin
         stall_cycles_next = stall_cycles_reg + 32'd1;
      end
   end

   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         stall_cycles_reg <= 32'd0;
      end else begin
         stall_cycles_reg <= stall_cycles_next;
      end
   end

   assign STALL_CYCLES = stall_cycles_reg;
`else
   assign STALL_CYCLES = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed pipeline scenarios plus
// randomized traffic checked against a ready-cycle reference model.
module tb_hazard_scoreboard;

   localparam int LD_EX  = 1;
   localparam int LD_ID  = 2;
   localparam int ALU_ID = 1;
`ifdef HAZARD_STALL_COUNT_EN
   localparam bit COUNT_EN = 1'b1;
`else
   localparam bit COUNT_EN = 1'b0;
`endif

   logic        CLOCK = 1'b0;
   logic        RESET = 1'b0;
   logic [31:0] Instruction_IN = '0;
   logic        ID_Valid = 1'b0;
   logic        ID_UsesRS = 1'b0;
   logic        ID_UsesRT = 1'b0;
   logic        ID_Branch = 1'b0;
   logic        ID_RegWrite = 1'b0;
   logic        ID_MemRead = 1'b0;
   logic [4:0]  ID_RegD = '0;
   logic        FLUSH = 1'b0;
   logic        STALL;
   logic        PC_Write;
   logic        IFID_Write;
   logic        IDEX_Bubble;
   logic [31:0] STALL_CYCLES;

   hazard_scoreboard #(
      .LOAD_EX_WAIT(LD_EX),
      .LOAD_ID_WAIT(LD_ID),
      .ALU_ID_WAIT (ALU_ID)
   ) dut (
      .CLOCK         (CLOCK),
      .RESET         (RESET),
      .Instruction_IN(Instruction_IN),
      .ID_Valid      (ID_Valid),
      .ID_UsesRS     (ID_UsesRS),
      .ID_UsesRT     (ID_UsesRT),
      .ID_Branch     (ID_Branch),
      .ID_RegWrite   (ID_RegWrite),
      .ID_MemRead    (ID_MemRead),
      .ID_RegD       (ID_RegD),
      .FLUSH         (FLUSH),
      .STALL         (STALL),
      .PC_Write      (PC_Write),
      .IFID_Write    (IFID_Write),
      .IDEX_Bubble   (IDEX_Bubble),
      .STALL_CYCLES  (STALL_CYCLES)
   );

   always #5 CLOCK = ~CLOCK;

   int tests_run = 0;
   int fail_count = 0;

   // Reference model: cycle number from which each register's value is forwardable.
   int          ready_ex [32];
   int          ready_id [32];
   int          cyc = 0;
   longint      exp_cnt = 0;

   task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         fail_count++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, actual, expected, $time);
      end
   endtask

   function automatic logic [31:0] exp_stall_cycles();
      if (!COUNT_EN) return 32'd0;
      if (exp_cnt > 64'hFFFF_FFFF) return 32'hFFFF_FFFF;
      return exp_cnt[31:0];
   endfunction

   task automatic model_reset();
      for (int r = 0; r < 32; r++) begin
         ready_ex[r] = 0;
         ready_id[r] = 0;
      end
      cyc = 0;
      exp_cnt = 0;
   endtask

   // Drives one ID-stage cycle (called just after a rising edge), checks the
   // combinational outputs, then advances the model across the next edge.
   task automatic step(input string tag, input logic valid, input logic flush,
                       input logic use_rs, input logic use_rt, input logic branch,
                       input logic regwrite, input logic memread,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       output logic seen_stall);
      logic hz_ex, hz_id, exp_stall, exp_issue;
      Instruction_IN = {6'h23, rs, rt, 16'(($urandom & 32'hFFFF))};
      ID_Valid = valid;
      FLUSH = flush;
      ID_UsesRS = use_rs;
      ID_UsesRT = use_rt;
      ID_Branch = branch;
      ID_RegWrite = regwrite;
      ID_MemRead = memread;
      ID_RegD = rd;
      #1;
      hz_ex = (use_rs && rs != 0 && cyc < ready_ex[rs]) || (use_rt && rt != 0 && cyc < ready_ex[rt]);
      hz_id = branch && ((use_rs && rs != 0 && cyc < ready_id[rs]) ||
                         (use_rt && rt != 0 && cyc < ready_id[rt]));
      exp_stall = valid && !flush && (hz_ex || hz_id);
      exp_issue = valid && !exp_stall && !flush && regwrite && rd != 0;
      check({tag, "_stall"}, 32'(STALL), 32'(exp_stall));
      check({tag, "_pcw"}, 32'(PC_Write), 32'(!exp_stall));
      check({tag, "_ifidw"}, 32'(IFID_Write), 32'(!exp_stall));
      check({tag, "_bubble"}, 32'(IDEX_Bubble), 32'(exp_stall));
      check({tag, "_cnt"}, STALL_CYCLES, exp_stall_cycles());
      seen_stall = STALL;
      @(posedge CLOCK);
      if (exp_stall) exp_cnt++;
      if (exp_issue) begin
         ready_ex[rd] = cyc + 1 + (memread ? LD_EX : 0);
         ready_id[rd] = cyc + 1 + (memread ? LD_ID : ALU_ID);
      end
      cyc++;
      #1;
   endtask

   task automatic idle_cycles(input int n);
      logic s;
      for (int i = 0; i < n; i++) step("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, s);
   endtask

   initial begin
      logic s;
      int   nstall;
      longint cnt_base;

      model_reset();
      #2;
      check("rst_stall", 32'(STALL), 32'd0);
      check("rst_pcw", 32'(PC_Write), 32'd1);
      check("rst_ifidw", 32'(IFID_Write), 32'd1);
      check("rst_bubble", 32'(IDEX_Bubble), 32'd0);
      check("rst_cnt", STALL_CYCLES, 32'd0);
      @(posedge CLOCK);
      #1;
      RESET = 1'b1;

      // Load $8 then add reading $8 via RS: one stall, then issue.
      cnt_base = exp_cnt;
      step("ld8", 1, 0, 1, 0, 0, 1, 1, 5'd1, 5'd0, 5'd8, s);
      nstall = 0;
      for (int i = 0; i < 4; i++) begin
         step("add8", 1, 0, 1, 0, 0, 1, 0, 5'd8, 5'd2, 5'd3, s);
         if (!s) break;
         nstall++;
      end
      check("ld_use_nstall", 32'(nstall), 32'd1);
      check("ld_use_cnt", STALL_CYCLES, COUNT_EN ? 32'(cnt_base + 1) : 32'd0);
      idle_cycles(3);

      // Load $9 then beq using $9 via RT: two stalls.
      step("ld9", 1, 0, 1, 0, 0, 1, 1, 5'd1, 5'd0, 5'd9, s);
      nstall = 0;
      for (int i = 0; i < 5; i++) begin
         step("beq9", 1, 0, 1, 1, 1, 0, 0, 5'd4, 5'd9, 5'd0, s);
         if (!s) break;
         nstall++;
      end
      check("ld_br_nstall", 32'(nstall), 32'd2);
      idle_cycles(3);

      // ALU result feeding a branch: one stall.
      step("add5", 1, 0, 1, 1, 0, 1, 0, 5'd1, 5'd2, 5'd5, s);
      nstall = 0;
      for (int i = 0; i < 4; i++) begin
         step("beq5", 1, 0, 1, 0, 1, 0, 0, 5'd5, 5'd0, 5'd0, s);
         if (!s) break;
         nstall++;
      end
      check("alu_br_nstall", 32'(nstall), 32'd1);
      idle_cycles(3);

      // Writes to $0 are never tracked.
      step("ld0", 1, 0, 1, 0, 0, 1, 1, 5'd1, 5'd0, 5'd0, s);
      step("beq0", 1, 0, 1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, s);
      check("zero_reg_nostall", 32'(s), 32'd0);
      idle_cycles(2);

      // WAW: the ALU write to $10 overwrites the pending load entry.
      step("ld10", 1, 0, 1, 0, 0, 1, 1, 5'd1, 5'd0, 5'd10, s);
      step("add10", 1, 0, 1, 0, 0, 1, 0, 5'd2, 5'd0, 5'd10, s);
      step("sub10", 1, 0, 1, 0, 0, 1, 0, 5'd10, 5'd0, 5'd11, s);
      check("waw_nostall", 32'(s), 32'd0);
      idle_cycles(3);

      // FLUSH during a load-use hazard: no stall and the squashed load to $12 is not recorded.
      step("ld8f", 1, 0, 1, 0, 0, 1, 1, 5'd1, 5'd0, 5'd8, s);
      step("flush", 1, 1, 1, 0, 0, 1, 1, 5'd8, 5'd0, 5'd12, s);
      check("flush_nostall", 32'(s), 32'd0);
      step("use12", 1, 0, 1, 0, 1, 0, 0, 5'd12, 5'd0, 5'd0, s);
      check("flush_noissue", 32'(s), 32'd0);
      idle_cycles(3);

      // Asynchronous reset during the first stall of a load-to-branch pair.
      step("ld9r", 1, 0, 1, 0, 0, 1, 1, 5'd1, 5'd0, 5'd9, s);
      Instruction_IN = {6'h04, 5'd9, 5'd0, 16'h0};
      ID_Valid = 1; FLUSH = 0; ID_UsesRS = 1; ID_UsesRT = 1; ID_Branch = 1;
      ID_RegWrite = 0; ID_MemRead = 0; ID_RegD = 0;
      #1;
      check("pre_rst_stall", 32'(STALL), 32'd1);
      #2;
      RESET = 1'b0;
      #1;
      check("async_rst_stall", 32'(STALL), 32'd0);
      check("async_rst_pcw", 32'(PC_Write), 32'd1);
      check("async_rst_cnt", STALL_CYCLES, 32'd0);
      model_reset();
      @(posedge CLOCK);
      #1;
      RESET = 1'b1;
      step("br_after_rst", 1, 0, 1, 1, 1, 0, 0, 5'd9, 5'd0, 5'd0, s);
      check("br_after_rst_nostall", 32'(s), 32'd0);

      // Randomized traffic over a small register window to force frequent hazards.
      for (int i = 0; i < 600; i++) begin
         logic v, f, ur, ut, br, rw, mr;
         logic [4:0] a, b, d;
         v  = ($urandom_range(0, 9) != 0);
         f  = ($urandom_range(0, 9) == 0);
         ur = $urandom_range(0, 1);
         ut = $urandom_range(0, 1);
         br = ($urandom_range(0, 3) == 0);
         rw = ($urandom_range(0, 3) != 0);
         mr = $urandom_range(0, 1);
         a  = 5'($urandom_range(0, 6));
         b  = 5'($urandom_range(0, 6));
         d  = 5'($urandom_range(0, 6));
         step("rand", v, f, ur, ut, br, rw, mr, a, b, d, s);
      end
      check("final_cnt", STALL_CYCLES, exp_stall_cycles());

      $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
